// File: rtl/freq_pkg.sv
// Shared definitions for the multi-channel reciprocal frequency counter.
//   ch_state_e            : per-channel measurement state (3-bit encoding)
//   DefaultW              : default width of each Nx / Ns result
//   DefaultGateCycles     : default gate length in reference clock cycles
//   DefaultTimeoutCycles  : default wait limit for the terminating edge
package freq_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StArm      = 3'd1,
    StCount    = 3'd2,
    StWaitEdge = 3'd3,
    StDone     = 3'd4
  } ch_state_e;

  localparam int unsigned DefaultW             = 40;
  localparam int unsigned DefaultGateCycles    = 72000000;
  localparam int unsigned DefaultTimeoutCycles = 72000000;

endpackage

// File: rtl/freq_ch.sv
// One measurement channel: 2-FF synchronizer, rising-edge detector, measurement FSM and
// saturating Nx (input periods) / Ns (reference cycles) counters.
// Ports:
//   clk_72MHz, rst_n       : reference clock, asynchronous active-low reset
//   freq_in                : asynchronous signal under measurement
//   gate_start, gate_end   : 1-cycle pulses from the shared gate timer
//   nx_out, ns_out         : latched result, held until the next DONE
//   valid                  : 1-cycle strobe while in DONE
//   no_signal, ovf         : flags belonging to the latched result
//   busy                   : channel is not IDLE
module freq_ch
  import freq_pkg::*;
#(
  parameter int unsigned W              = DefaultW,
  parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
  input  logic         clk_72MHz,
  input  logic         rst_n,
  input  logic         freq_in,
  input  logic         gate_start,
  input  logic         gate_end,
  output logic [W-1:0] nx_out,
  output logic [W-1:0] ns_out,
  output logic         valid,
  output logic         no_signal,
  output logic         ovf,
  output logic         busy
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TimeoutLast = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [W-1:0] CntMax = '1;

  logic          sync1_q, sync2_q, prev_q;
  logic          edge_ev;
  ch_state_e     state_q;
  logic [W-1:0]  nx_q, ns_q;
  logic [W-1:0]  nx_inc, ns_inc;
  logic [TW-1:0] wait_q;

  always_ff @(posedge clk_72MHz or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= freq_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign edge_ev = sync2_q & ~prev_q;

  // Counters stick at all-ones instead of wrapping.
  assign nx_inc = (nx_q == CntMax) ? CntMax : nx_q + W'(1);
  assign ns_inc = (ns_q == CntMax) ? CntMax : ns_q + W'(1);

  always_ff @(posedge clk_72MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      nx_q      <= '0;
      ns_q      <= '0;
      wait_q    <= '0;
      nx_out    <= '0;
      ns_out    <= '0;
      valid     <= 1'b0;
      no_signal <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state_q)
        StIdle: begin
          if (gate_start) state_q <= StArm;
        end
        StArm: begin
          if (gate_end) begin
            // Gate closed before any edge arrived.
            nx_out    <= '0;
            ns_out    <= '0;
            no_signal <= 1'b1;
            ovf       <= 1'b0;
            valid     <= 1'b1;
            state_q   <= StDone;
          end else if (edge_ev) begin
            nx_q    <= '0;
            ns_q    <= '0;
            state_q <= StCount;
          end
        end
        StCount: begin
          ns_q <= ns_inc;
          if (edge_ev) nx_q <= nx_inc;
          // A coincident edge is counted above and does not end the measurement.
          if (gate_end) begin
            wait_q  <= '0;
            state_q <= StWaitEdge;
          end
        end
        StWaitEdge: begin
          ns_q   <= ns_inc;
          wait_q <= wait_q + TW'(1);
          if (edge_ev) begin
            nx_out    <= nx_inc;
            ns_out    <= ns_inc;
            no_signal <= 1'b0;
            ovf       <= (&nx_inc) | (&ns_inc);
            valid     <= 1'b1;
            state_q   <= StDone;
          end else if (wait_q == TimeoutLast) begin
            nx_out    <= nx_q;
            ns_out    <= ns_inc;
            no_signal <= 1'b1;
            ovf       <= (&nx_q) | (&ns_inc);
            valid     <= 1'b1;
            state_q   <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy = (state_q != StIdle);

endmodule

// File: rtl/freq_measure_multi.sv
// Multi-channel reciprocal frequency counter with a shared gate timer.
// Ports:
//   clk_72MHz, rst_n : reference clock, asynchronous active-low reset
//   mode             : 0 = continuous gating, 1 = single-shot
//   start            : single-shot launch pulse (ignored in continuous mode)
//   freq_in          : CHANNELS asynchronous inputs
//   nx_out, ns_out   : per-channel results, channel k at [k*W +: W]
//   valid            : per-channel result strobe
//   no_signal, ovf   : per-channel flags for the latched result
//   busy             : any channel not IDLE
module freq_measure_multi
  import freq_pkg::*;
#(
  parameter int unsigned CHANNELS       = 4,
  parameter int unsigned W              = DefaultW,
  parameter int unsigned GATE_CYCLES    = DefaultGateCycles,
  parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
  input  logic                  clk_72MHz,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic                  start,
  input  logic [CHANNELS-1:0]   freq_in,
  output logic [CHANNELS*W-1:0] nx_out,
  output logic [CHANNELS*W-1:0] ns_out,
  output logic [CHANNELS-1:0]   valid,
  output logic [CHANNELS-1:0]   no_signal,
  output logic [CHANNELS-1:0]   ovf,
  output logic                  busy
);

  localparam int unsigned GW = $clog2(GATE_CYCLES + 1);

  logic [GW-1:0]       gate_cnt_q;
  logic                gate_run_q;
  logic                gate_start, gate_end;
  logic [CHANNELS-1:0] ch_busy;

  // Continuous: the count wraps every GATE_CYCLES and each wrap both ends one gate and
  // opens the next. Single-shot: start loads 1, so the count equals cycles since start.
  always_comb begin
    gate_start = 1'b0;
    gate_end   = 1'b0;
    if (!mode) begin
      gate_start = (gate_cnt_q == '0);
      gate_end   = gate_start;
    end else begin
      gate_start = start;
      gate_end   = gate_run_q && (gate_cnt_q == GW'(GATE_CYCLES));
    end
  end

  always_ff @(posedge clk_72MHz or negedge rst_n) begin
    if (!rst_n) begin
      gate_cnt_q <= '0;
      gate_run_q <= 1'b0;
    end else if (!mode) begin
      gate_run_q <= 1'b0;
      gate_cnt_q <= (gate_cnt_q >= GW'(GATE_CYCLES - 1)) ? '0 : gate_cnt_q + GW'(1);
    end else if (start) begin
      gate_cnt_q <= GW'(1);
      gate_run_q <= 1'b1;
    end else if (gate_end) begin
      gate_cnt_q <= '0;
      gate_run_q <= 1'b0;
    end else if (gate_run_q) begin
      gate_cnt_q <= gate_cnt_q + GW'(1);
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    freq_ch #(
      .W              (W),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_ch (
      .clk_72MHz  (clk_72MHz),
      .rst_n      (rst_n),
      .freq_in    (freq_in[k]),
      .gate_start (gate_start),
      .gate_end   (gate_end),
      .nx_out     (nx_out[k*W +: W]),
      .ns_out     (ns_out[k*W +: W]),
      .valid      (valid[k]),
      .no_signal  (no_signal[k]),
      .ovf        (ovf[k]),
      .busy       (ch_busy[k])
    );
  end

  assign busy = |ch_busy;

endmodule
